// File: rtl/shift_reg_sequencer_pkg.sv
// Shared encodings for the shift register sequencer: command opcodes and FSM states.
package shift_reg_seq_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/shift_reg_sequencer_if.sv
// Command channel between a requester and the sequencer (valid/ready handshake).
interface shift_reg_sequencer_if
  import shift_reg_seq_pkg::*;
#(
  parameter int REG_WIDTH = 8,
  parameter int CNT_W     = $clog2(REG_WIDTH) + 1
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [OP_W-1:0]      cmd_op;
  logic [CNT_W-1:0]     cmd_count;
  logic [REG_WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_count,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_count,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/shift_reg_sequencer_counter.sv
// Shift-cycle down-counter; loads the requested count clamped to MAX_COUNT.
module sat_down_counter #(
  parameter int CNT_W     = 4,
  parameter int MAX_COUNT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             en,
  output logic             last
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] value;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= (load_value > SAT) ? SAT : load_value;
    end else if (en && (value != '0)) begin
      value <= value - CNT_W'(1);
    end
  end

  assign last = (value == CNT_W'(1));

endmodule

// File: rtl/shift_reg_sequencer.sv
// Turns LOAD/SHIFT/CLEAR commands into registered load/shift strobes for a shift register.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | ready for a command (cmd_ready high)
// ST_LOAD  | load strobe high for one cycle (LOAD or CLEAR)
// ST_SHIFT | shift strobe high, one cycle per counted shift
// ST_DONE  | done pulse, back to idle next cycle
module shift_reg_sequencer
  import shift_reg_seq_pkg::*;
#(
  parameter int REG_WIDTH = 8,
  parameter int CNT_W     = $clog2(REG_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_reg_sequencer_if.slave cmd,
  output logic                 load,
  output logic                 shift_en,
  output logic                 shift_left_right,
  output logic [REG_WIDTH-1:0] data_in,
  output logic                 busy,
  output logic                 done
);

  state_e state, next_state;
  op_e    op;
  logic   ready_q;
  logic   accept;
  logic   is_shift_op;
  logic   cnt_last;

  assign op          = op_e'(cmd.cmd_op);
  assign accept      = cmd.cmd_valid && ready_q;
  assign is_shift_op = (op == OP_SHL) || (op == OP_SHR);
  assign cmd.cmd_ready = ready_q;

  sat_down_counter #(
    .CNT_W     (CNT_W),
    .MAX_COUNT (REG_WIDTH)
  ) u_shift_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept && is_shift_op),
    .load_value (cmd.cmd_count),
    .en         (state == ST_SHIFT),
    .last       (cnt_last)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift_op) begin
            next_state = (cmd.cmd_count == '0) ? ST_DONE : ST_SHIFT;
          end else begin
            next_state = ST_LOAD;
          end
        end
      end
      ST_LOAD:  next_state = ST_DONE;
      ST_SHIFT: if (cnt_last) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state so each strobe is a flop aligned with its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      ready_q          <= 1'b0;
      load             <= 1'b0;
      shift_en         <= 1'b0;
      shift_left_right <= 1'b0;
      data_in          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state    <= next_state;
      ready_q  <= (next_state == ST_IDLE);
      load     <= (next_state == ST_LOAD);
      shift_en <= (next_state == ST_SHIFT);
      busy     <= (next_state != ST_IDLE);
      done     <= (next_state == ST_DONE);
      if (accept) begin
        case (op)
          OP_LOAD: data_in <= cmd.cmd_data;
          OP_CLR:  data_in <= '0;
          OP_SHL:  if (cmd.cmd_count != '0) shift_left_right <= 1'b1;
          OP_SHR:  if (cmd.cmd_count != '0) shift_left_right <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer with a shadow model of the controlled register.
module tb_shift_reg_sequencer;

  localparam int RW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load, shift_en, shift_left_right, busy, done;
  logic [RW-1:0] data_in;

  shift_reg_sequencer_if #(.REG_WIDTH(RW), .CNT_W(CW)) cmd_bus ();

  shift_reg_sequencer #(.REG_WIDTH(RW), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd              (cmd_bus),
    .load             (load),
    .shift_en         (shift_en),
    .shift_left_right (shift_left_right),
    .data_in          (data_in),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] shadow = '0;
  int overlap = 0;
  int done_total = 0;

  always @(posedge clk) begin
    if (load && shift_en) overlap <= overlap + 1;
    if (done) done_total <= done_total + 1;
    if (load) shadow <= data_in;
    else if (shift_en) shadow <= shift_left_right ? (shadow << 1) : (shadow >> 1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int n_load, n_shift, t_done, t_ready, slr_bad;
  logic [RW-1:0] load_val;
  logic slr_seen;

  // Called at a negedge; waits (bounded) until cmd_ready is visible.
  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!cmd_bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_bus.cmd_ready;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [CW-1:0] cnt, input logic [RW-1:0] dat);
    bit ok;
    bit first = 1'b1;
    n_load = 0; n_shift = 0; t_done = -1; t_ready = -1; slr_bad = 0; load_val = 'x;
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_count = cnt;
    cmd_bus.cmd_data  = dat;
    wait_ready(ok);
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 cmd_bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (load) begin n_load++; load_val = data_in; end
      if (shift_en) begin
        n_shift++;
        if (first) begin slr_seen = shift_left_right; first = 1'b0; end
        else if (shift_left_right != slr_seen) slr_bad++;
      end
      if (done && t_done < 0) t_done = k;
      if (cmd_bus.cmd_ready) begin t_ready = k; break; end
    end
  endtask

  initial begin
    bit ok;
    int acc2, load2_cyc, done_win, load_win;
    logic [RW-1:0] load2_val;
    int done_before;

    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 2'b00;
    cmd_bus.cmd_count = '0;
    cmd_bus.cmd_data  = '0;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs",
            {26'd0, cmd_bus.cmd_ready, load, shift_en, shift_left_right, busy, done}, 0);
      check("reset_data_in", data_in, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_bus.cmd_ready, 1);

    // LOAD A5
    run_cmd(2'b00, 4'd0, 8'hA5);
    check("load_pulses", n_load, 1);
    check("load_data", load_val, 8'hA5);
    check("load_no_shift", n_shift, 0);
    check("load_done_t", t_done, 2);
    check("load_ready_t", t_ready, 3);
    check("load_shadow", shadow, 8'hA5);

    // LOAD 1 then SHIFT_LEFT 3
    run_cmd(2'b00, 4'd0, 8'h01);
    check("load1_done_t", t_done, 2);
    run_cmd(2'b01, 4'd3, 8'h00);
    check("shl3_count", n_shift, 3);
    check("shl3_dir", slr_seen, 1);
    check("shl3_dir_stable", slr_bad, 0);
    check("shl3_done_t", t_done, 4);
    check("shl3_ready_t", t_ready, 5);
    check("shl3_shadow", shadow, 8'h08);

    // SHIFT_RIGHT count 0
    run_cmd(2'b10, 4'd0, 8'h00);
    check("shr0_count", n_shift, 0);
    check("shr0_done_t", t_done, 1);
    check("shr0_ready_t", t_ready, 2);
    check("shr0_shadow", shadow, 8'h08);

    // LOAD FF then SHIFT_RIGHT 15 saturates to 8
    run_cmd(2'b00, 4'd0, 8'hFF);
    run_cmd(2'b10, 4'd15, 8'h00);
    check("shr15_count", n_shift, 8);
    check("shr15_dir", slr_seen, 0);
    check("shr15_done_t", t_done, 9);
    check("shr15_shadow", shadow, 8'h00);

    // Back-to-back: CLEAR then LOAD FF with cmd_valid held high
    run_cmd(2'b00, 4'd0, 8'h5A);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = 2'b11;
    wait_ready(ok);
    if (!ok) check("b2b_accept_timeout", 0, 1);
    done_before = done_total;
    @(posedge clk);
    #1;
    cmd_bus.cmd_op   = 2'b00;
    cmd_bus.cmd_data = 8'hFF;
    acc2 = -1; load2_cyc = -1; load_win = 0; load2_val = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (acc2 >= 0) cmd_bus.cmd_valid = 1'b0;
      if (load) begin
        load_win++;
        if (k > 1 && load2_cyc < 0) begin load2_cyc = k; load2_val = data_in; end
      end
      if (cmd_bus.cmd_ready && acc2 < 0) acc2 = k;
    end
    done_win = done_total - done_before;
    check("b2b_second_accept", acc2, 3);
    check("b2b_second_load_cyc", load2_cyc, 4);
    check("b2b_second_load_val", load2_val, 8'hFF);
    check("b2b_load_pulses", load_win, 2);
    check("b2b_done_pulses", done_win, 2);
    check("b2b_shadow", shadow, 8'hFF);

    // Reset in the 4th shift cycle of SHIFT_LEFT 8
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = 2'b01;
    cmd_bus.cmd_count = 4'd8;
    wait_ready(ok);
    if (!ok) check("rst_accept_timeout", 0, 1);
    @(posedge clk);
    #1 cmd_bus.cmd_valid = 1'b0;
    done_before = done_total;
    n_shift = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (shift_en) n_shift++;
    end
    check("rst_shifts_before", n_shift, 4);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_strobes_drop", {29'd0, shift_en, load, busy}, 0);
    check("rst_ready_low", cmd_bus.cmd_ready, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("rst_no_done", done_total - done_before, 0);
    run_cmd(2'b00, 4'd0, 8'h3C);
    check("post_rst_done_t", t_done, 2);
    check("post_rst_shadow", shadow, 8'h3C);

    check("load_shift_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
